log_window_sequencer: RTL and testbench

- Streaming controller that feeds the 5x5 LoG edge-enhancement kernel.
- Accepts a raster-order 8-bit grayscale frame (from the JPEG colour/IDCT output stage) over a valid/ready stream.
- Buffers four lines plus a 5x5 register window, presents each window to the kernel on a 200-bit bus, and streams the enhanced frame out in raster order.
- Border pixels whose window leaves the frame bypass the kernel; FLUSH drains the last two rows after input ends.

---
 rtl/log_window_sequencer_pkg.sv | 23 ++
 rtl/log_line_buffer.sv | 42 ++++
 rtl/log_window_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_log_window_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/log_window_sequencer_pkg.sv
// Shared definitions for the LoG window sequencer.
// Holds the sequencer state encoding, the window geometry and the helper
// that maps a (row, col) window position to its byte slot on the window bus.
package log_seq_pkg;

    localparam int KW       = 5;               // window is KW x KW pixels
    localparam int PIX_W    = 8;               // grayscale pixel width
    localparam int WIN_BITS = KW * KW * PIX_W; // 200-bit window bus

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Byte index of window position (row, col); row 0 is the oldest line,
    // col 0 the oldest column.
    function automatic int win_byte(input int row, input int col);
        return row * KW + col;
    endfunction

endpackage

// File: rtl/log_line_buffer.sv
// Four chained line delays feeding the upper rows of the 5x5 window.
// Ports:
//   clk    - clock
//   we_i   - advance: shift the pixel at col_i one line down the chain
//   col_i  - current column (shared address of all four lines)
//   pix_i  - pixel entering the newest line
//   taps_o - tap j holds the pixel j+1 lines above the incoming one
//            (tap 0 = previous line, tap 3 = four lines back)
// Reads return the contents before the write of the same cycle.
module log_line_buffer
    import log_seq_pkg::*;
#(
    parameter int MAX_W = 1024,
    parameter int AW    = 10
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [AW-1:0]             col_i,
    input  logic [PIX_W-1:0]          pix_i,
    output logic [(KW-1)*PIX_W-1:0]   taps_o
);

    logic [PIX_W-1:0] mem_q [KW-1][MAX_W];

    // Asynchronous read of all four lines at the current column
    always_comb begin
        for (int j = 0; j < KW - 1; j++) begin
            taps_o[j*PIX_W +: PIX_W] = mem_q[j][col_i];
        end
    end

    // Push the new pixel into line 0 and move each older pixel one line down
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[0][col_i] <= pix_i;
            for (int j = 1; j < KW - 1; j++) begin
                mem_q[j][col_i] <= mem_q[j-1][col_i];
            end
        end
    end

endmodule

// File: rtl/log_window_sequencer.sv
// Streaming controller for the 5x5 LoG kernel.
// Takes a raster frame on s_*, keeps a 5x5 window over four line delays,
// shows it on win_data, and emits the enhanced frame on m_* (border pixels
// pass through unchanged, interior pixels take kern_pixel).
// Ports:
//   start/cfg_width/cfg_height - begin a frame (ignored unless idle and legal)
//   busy/done                  - frame in progress / one-cycle completion pulse
//   s_valid/s_ready/s_data     - input pixel stream
//   win_data/kern_pixel        - window to kernel, combinational kernel result
//   m_valid/m_ready/m_data/m_last - output pixel stream
// The window register is one stage ahead of the output register: the window
// built by an advance is turned into m_data on the next free output slot.
module log_window_sequencer
    import log_seq_pkg::*;
#(
    parameter int MAX_W = 1024,
    parameter int CW    = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CW-1:0]       cfg_width,
    input  logic [CW-1:0]       cfg_height,
    output logic                busy,
    output logic                done,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [PIX_W-1:0]    s_data,
    output logic [WIN_BITS-1:0] win_data,
    input  logic [PIX_W-1:0]    kern_pixel,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [PIX_W-1:0]    m_data,
    output logic                m_last
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int FW = CW + 2;   // wide enough for 2*W+2

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       w_q, w_d, h_q, h_d;
    logic [CW-1:0]       in_col_q, in_col_d, in_row_q, in_row_d;
    logic [FW-1:0]       prime_q, prime_d, flush_q, flush_d;
    logic [CW-1:0]       out_col_q, out_col_d, out_row_q, out_row_d;
    logic                pend_q, pend_d;
    logic [WIN_BITS-1:0] win_q, win_d;
    logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [PIX_W-1:0]    m_data_q, m_data_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic                cfg_ok_s, start_acc_s, fire_s, in_acc_s, flush_step_s, adv_s;
    logic                last_col_s, last_in_s, prime_full_s, bypass_s, out_last_s;
    logic [FW-1:0]       flush_len_s;
    logic [PIX_W-1:0]    adv_pix_s, centre_s;
    logic [(KW-1)*PIX_W-1:0] taps_s;

    assign cfg_ok_s     = (cfg_width >= CW'(KW)) && (cfg_width <= CW'(MAX_W)) &&
                          (cfg_height >= CW'(KW));
    assign start_acc_s  = (state_q == IDLE) && start && cfg_ok_s;
    assign fire_s       = !m_valid_q || m_ready;
    assign s_ready      = (state_q == RUN) && fire_s;
    assign in_acc_s     = s_ready && s_valid;
    assign flush_len_s  = {1'b0, w_q, 1'b0} + FW'(2);
    assign flush_step_s = (state_q == FLUSH) && fire_s && (flush_q != flush_len_s);
    assign adv_s        = in_acc_s || flush_step_s;
    assign adv_pix_s    = in_acc_s ? s_data : {PIX_W{1'b0}};
    assign last_col_s   = (in_col_q == w_q - CW'(1));
    assign last_in_s    = in_acc_s && last_col_s && (in_row_q == h_q - CW'(1));
    // Saturates once the window centre has reached frame pixel 0
    assign prime_full_s = (prime_q == flush_len_s);
    assign centre_s     = win_q[PIX_W*win_byte(KW/2, KW/2) +: PIX_W];
    assign bypass_s     = (out_row_q < CW'(2)) || (out_row_q >= h_q - CW'(2)) ||
                          (out_col_q < CW'(2)) || (out_col_q >= w_q - CW'(2));
    assign out_last_s   = (out_row_q == h_q - CW'(1)) && (out_col_q == w_q - CW'(1));
    assign busy_d       = (state_d == RUN) || (state_d == FLUSH);
    assign done_d       = (state_d == DONE);

    log_line_buffer #(.MAX_W(MAX_W), .AW(AW)) u_lines (
        .clk    (clk),
        .we_i   (adv_s),
        .col_i  (in_col_q[AW-1:0]),
        .pix_i  (adv_pix_s),
        .taps_o (taps_s)
    );

    // Frame-level state transitions and config capture
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            IDLE: begin
                if (start_acc_s) begin
                    state_d = RUN;
                    w_d     = cfg_width;
                    h_d     = cfg_height;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_in_s) state_d = FLUSH;
                else           state_d = RUN;
            end
            FLUSH: begin
                if (m_valid_q && m_ready && m_last_q) state_d = DONE;
                else                                  state_d = FLUSH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input-side column/row tracking, priming count and flush count
    always_comb begin
        in_col_d = in_col_q;
        in_row_d = in_row_q;
        prime_d  = prime_q;
        flush_d  = flush_q;
        if (start_acc_s) begin
            in_col_d = {CW{1'b0}};
            in_row_d = {CW{1'b0}};
            prime_d  = {FW{1'b0}};
            flush_d  = {FW{1'b0}};
        end else if (adv_s) begin
            if (last_col_s) begin
                in_col_d = {CW{1'b0}};
                in_row_d = in_row_q + CW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
            if (!prime_full_s) prime_d = prime_q + FW'(1);
            else               prime_d = prime_q;
            if (flush_step_s)  flush_d = flush_q + FW'(1);
            else               flush_d = flush_q;
        end else begin
            in_col_d = in_col_q;
        end
    end

    // Window shift: drop the oldest column, append line taps plus new pixel
    always_comb begin
        win_d = win_q;
        if (adv_s) begin
            for (int r = 0; r < KW; r++) begin
                for (int c = 0; c < KW - 1; c++) begin
                    win_d[PIX_W*win_byte(r, c) +: PIX_W] = win_q[PIX_W*win_byte(r, c + 1) +: PIX_W];
                end
            end
            for (int r = 0; r < KW - 1; r++) begin
                win_d[PIX_W*win_byte(r, KW - 1) +: PIX_W] = taps_s[(KW-2-r)*PIX_W +: PIX_W];
            end
            win_d[PIX_W*win_byte(KW - 1, KW - 1) +: PIX_W] = adv_pix_s;
        end else begin
            win_d = win_q;
        end
    end

    // Output register load from the pending window, centre position tracking
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        pend_d    = pend_q;
        if (start_acc_s) begin
            out_col_d = {CW{1'b0}};
            out_row_d = {CW{1'b0}};
            pend_d    = 1'b0;
        end else if (fire_s) begin
            pend_d = adv_s && prime_full_s;
            if (pend_q) begin
                m_valid_d = 1'b1;
                m_data_d  = bypass_s ? centre_s : kern_pixel;
                m_last_d  = out_last_s;
                if (out_col_q == w_q - CW'(1)) begin
                    out_col_d = {CW{1'b0}};
                    out_row_d = out_row_q + CW'(1);
                end else begin
                    out_col_d = out_col_q + CW'(1);
                end
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // All state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            w_q       <= {CW{1'b0}};
            h_q       <= {CW{1'b0}};
            in_col_q  <= {CW{1'b0}};
            in_row_q  <= {CW{1'b0}};
            prime_q   <= {FW{1'b0}};
            flush_q   <= {FW{1'b0}};
            out_col_q <= {CW{1'b0}};
            out_row_q <= {CW{1'b0}};
            pend_q    <= 1'b0;
            win_q     <= {WIN_BITS{1'b0}};
            m_valid_q <= 1'b0;
            m_data_q  <= {PIX_W{1'b0}};
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            prime_q   <= prime_d;
            flush_q   <= flush_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            pend_q    <= pend_d;
            win_q     <= win_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign win_data = win_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;

endmodule

// File: tb/tb_log_window_sequencer.sv
// Bench for log_window_sequencer: a table of frames run back to back, each
// checked pixel-by-pixel against a reference model of the frame, plus
// hand-written reset, illegal-config and mid-frame-reset sequences.
module tb_log_window_sequencer;

    localparam int MAX_W = 1024;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_width = '0;
    logic [CW-1:0] cfg_height = '0;
    logic          busy, done, s_ready, m_valid, m_last;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic [199:0]  win_data;
    logic [7:0]    kern_pixel;
    logic          m_ready = 1'b1;
    logic [7:0]    m_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] fr [0:127];
    int fw, fh;

    typedef struct {
        int w; int h; int pat; bit rnd; bit frz; int pre; int anc_i; int anc_v;
    } frame_vec_t;
    frame_vec_t vecs [7];

    log_window_sequencer #(.MAX_W(MAX_W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .busy(busy), .done(done), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .win_data(win_data),
        .kern_pixel(kern_pixel), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Test kernel: zero-DC Laplacian-like sum plus identity, made asymmetric
    // with (oldest corner - newest corner) so orientation errors show up.
    int ksum_s, kv_s;
    always_comb begin
        ksum_s = 0;
        for (int k = 0; k < 25; k++) ksum_s += int'(win_data[k*8 +: 8]);
        kv_s = ksum_s - 24 * int'(win_data[103:96]) + int'(win_data[7:0]) - int'(win_data[199:192]);
        kern_pixel = 8'(kv_s);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pat, input int i);
        case (pat)
            0:       return 8'd100;
            1:       return 8'(i);
            2:       return 8'(i * 37 + 11);
            3:       return 8'(i * 3);
            default: return 8'(200 + i);
        endcase
    endfunction

    function automatic logic [7:0] exp_pix(input int idx);
        int r, c, sum, v;
        r = idx / fw;
        c = idx % fw;
        if (r < 2 || r >= fh - 2 || c < 2 || c >= fw - 2) return fr[idx];
        sum = 0;
        for (int dr = -2; dr <= 2; dr++)
            for (int dc = -2; dc <= 2; dc++)
                sum += int'(fr[(r + dr) * fw + c + dc]);
        v = sum - 24 * int'(fr[idx]) + int'(fr[(r - 2) * fw + c - 2]) - int'(fr[(r + 2) * fw + c + 2]);
        return 8'(v);
    endfunction

    task automatic check_reset(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_s_ready"}, s_ready, 0);
        chk({p, "_m_valid"}, m_valid, 0);
        chk({p, "_m_last"}, m_last, 0);
        chk({p, "_m_data"}, m_data, 0);
        chk({p, "_win_zero"}, (win_data == 200'd0) ? 1 : 0, 1);
    endtask

    // Window for centre (2,2) of a ramp frame: byte k = frame (k/5, k%5)
    task automatic check_window();
        for (int k = 0; k < 25; k++)
            chk($sformatf("win_byte[%0d]", k), win_data[k*8 +: 8], (k / 5) * fw + (k % 5));
    endtask

    task automatic illegal_start();
        @(negedge clk);
        start = 1'b1; cfg_width = CW'(4); cfg_height = CW'(5); s_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("illegal_busy", busy, 0);
            chk("illegal_s_ready", s_ready, 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic mid_reset();
        int cnt, cyc;
        cnt = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; cfg_width = CW'(10); cfg_height = CW'(10); m_ready = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cnt < 20 && cyc < 200) begin
            s_valid = 1'b1; s_data = 8'(cnt + 50);
            #1;
            if (s_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        chk("mid_inputs", cnt, 20);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int n, in_idx, out_idx, cyc, budget, frz_cnt, done_cnt;
        bit finished, last_seen, prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        fw = v.w; fh = v.h; n = fw * fh;
        for (int i = 0; i < n; i++) fr[i] = pix_val(v.pat, i);
        @(negedge clk);
        start = 1'b1; cfg_width = CW'(fw); cfg_height = CW'(fh); s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        in_idx = 0; out_idx = 0; cyc = 0; frz_cnt = 0; done_cnt = 0;
        finished = 0; last_seen = 0; prev_stall = 0; prev_data = 8'd0; prev_last = 1'b0;
        budget = 30 * n + 100;
        while (!finished && cyc < budget) begin
            s_valid = (in_idx < n) && (!v.rnd || $urandom_range(1, 0) == 1);
            s_data  = (in_idx < n) ? fr[in_idx] : 8'd0;
            m_ready = !v.rnd || $urandom_range(1, 0) == 1;
            if (v.frz && m_valid && out_idx == 15 && frz_cnt < 3) begin
                m_ready = 1'b0;
                if (frz_cnt == 1) check_window();
                frz_cnt++;
            end
            #1;
            if (done) done_cnt++;
            if (last_seen) begin
                chk("done_after_last", done, 1);
                finished = 1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                    chk("stall_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    chk($sformatf("out_data[%0d]", out_idx), m_data, exp_pix(out_idx));
                    chk($sformatf("out_last[%0d]", out_idx), m_last, (out_idx == n - 1) ? 1 : 0);
                    if (out_idx == v.anc_i) chk("anchor", m_data, v.anc_v);
                    if (out_idx == n - 1) last_seen = 1;
                    out_idx++;
                end
                if (s_valid && s_ready) in_idx++;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                @(negedge clk);
                cyc++;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("frame_finished", finished, 1);
        chk("out_count", out_idx, n);
        chk("in_count", in_idx, n);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{w:8, h:6, pat:0, rnd:1'b0, frz:1'b0, pre:0, anc_i:20, anc_v:100};
        vecs[1] = '{w:7, h:5, pat:1, rnd:1'b0, frz:1'b1, pre:0, anc_i:16, anc_v:240};
        vecs[2] = '{w:9, h:7, pat:2, rnd:1'b1, frz:1'b0, pre:0, anc_i:0,  anc_v:11};
        vecs[3] = '{w:5, h:5, pat:1, rnd:1'b0, frz:1'b0, pre:1, anc_i:12, anc_v:244};
        vecs[4] = '{w:6, h:6, pat:3, rnd:1'b0, frz:1'b0, pre:2, anc_i:14, anc_v:214};
        vecs[5] = '{w:5, h:6, pat:4, rnd:1'b0, frz:1'b0, pre:0, anc_i:0,  anc_v:200};
        vecs[6] = '{w:6, h:5, pat:3, rnd:1'b0, frz:1'b0, pre:0, anc_i:14, anc_v:214};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pre == 1)      illegal_start();
            else if (vecs[i].pre == 2) mid_reset();
            run_frame(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
